// File: rtl/cache_ctrl_dm4.sv
// Direct-mapped 4-set write-back/write-allocate cache controller, 128-bit lines.
// Owns line/tag/valid/dirty storage and sequences hits, writebacks and fills.
module cache_ctrl_dm4 (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {COMPARE, WRITEBACK, FILL} state_e;

  state_e              state_q;
  logic [3:0][127:0]   line_q;
  logic [3:0][9:0]     tag_q;
  logic [3:0]          valid_q;
  logic [3:0]          dirty_q;
  logic                pmem_read_q;
  logic                pmem_write_q;
  logic [15:0]         pmem_addr_q;

  logic [1:0]   idx;
  logic [9:0]   tag_in;
  logic [6:0]   woff;
  logic         req;
  logic         hit;
  logic [127:0] line_sel;
  logic [15:0]  word_sel;
  logic [15:0]  word_merged;

  assign idx      = mem_address[5:4];
  assign tag_in   = mem_address[15:6];
  assign woff     = {mem_address[3:1], 4'b0000};
  assign req      = mem_read | mem_write;
  assign hit      = valid_q[idx] && (tag_q[idx] == tag_in);
  assign line_sel = line_q[idx];
  assign word_sel = line_sel[woff +: 16];

  assign word_merged = {mem_byte_enable[1] ? mem_wdata[15:8] : word_sel[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : word_sel[7:0]};

  // Outputs are forced quiet while reset is asserted, before the arrays clear.
  assign mem_resp     = ~reset && (state_q == COMPARE) && req && hit;
  assign mem_rdata    = reset ? 16'h0 : word_sel;
  assign pmem_wdata   = reset ? 128'h0 : line_sel;
  assign pmem_read    = pmem_read_q  & ~reset;
  assign pmem_write   = pmem_write_q & ~reset;
  assign pmem_address = reset ? 16'h0 : pmem_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COMPARE;
      line_q       <= '0;
      tag_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= 16'h0;
    end else begin
      case (state_q)
        COMPARE: begin
          if (req && hit) begin
            if (mem_write) begin
              line_q[idx][woff +: 16] <= word_merged;
              dirty_q[idx]            <= 1'b1;
            end
          end else if (req) begin
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
              pmem_addr_q  <= {tag_q[idx], idx, 4'b0000};
            end else begin
              state_q     <= FILL;
              pmem_read_q <= 1'b1;
              pmem_addr_q <= {tag_in, idx, 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_q[idx] <= 1'b0;
            pmem_write_q <= 1'b0;
            // A dropped request still finishes the writeback, then idles.
            if (req) begin
              state_q     <= FILL;
              pmem_read_q <= 1'b1;
              pmem_addr_q <= {tag_in, idx, 4'b0000};
            end else begin
              state_q     <= COMPARE;
              pmem_addr_q <= 16'h0;
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            line_q[idx]  <= pmem_rdata;
            tag_q[idx]   <= tag_in;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state_q      <= COMPARE;
            pmem_read_q  <= 1'b0;
            pmem_addr_q  <= 16'h0;
          end
        end
        default: begin
          state_q      <= COMPARE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
          pmem_addr_q  <= 16'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_dm4.sv
// Bench for cache_ctrl_dm4: per-cycle comparison against a behavioural cache
// model, a backing physical memory, and directed literal expectations.
module tb_cache_ctrl_dm4;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int failures = 0;

  cache_ctrl_dm4 dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Physical memory: lines not explicitly stored hold word w = line_addr + w.
  logic [127:0] backing [int];

  function automatic logic [127:0] pmem_get(input logic [15:0] a);
    logic [127:0] r;
    if (backing.exists(int'(a))) return backing[int'(a)];
    for (int w = 0; w < 8; w++) r[w*16 +: 16] = a + 16'(w);
    return r;
  endfunction

  // Behavioural cache model. phase: 0 = idle, 1 = writing back, 2 = filling.
  logic [127:0] m_line  [4];
  logic [9:0]   m_tag   [4];
  bit           m_valid [4];
  bit           m_dirty [4];
  int           m_phase;

  always @(posedge clk) begin
    int i;
    logic [15:0] oldw, neww;
    i = int'(mem_address[5:4]);
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        m_line[k] <= '0; m_tag[k] <= '0; m_valid[k] <= 0; m_dirty[k] <= 0;
      end
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (mem_read || mem_write) begin
        if (m_valid[i] && m_tag[i] == mem_address[15:6]) begin
          if (mem_write) begin
            oldw = m_line[i][mem_address[3:1]*16 +: 16];
            neww[7:0]  = mem_byte_enable[0] ? mem_wdata[7:0]  : oldw[7:0];
            neww[15:8] = mem_byte_enable[1] ? mem_wdata[15:8] : oldw[15:8];
            m_line[i][mem_address[3:1]*16 +: 16] <= neww;
            m_dirty[i] <= 1;
          end
        end else begin
          m_phase <= (m_valid[i] && m_dirty[i]) ? 1 : 2;
        end
      end
    end else if (m_phase == 1) begin
      if (pmem_resp) begin
        m_dirty[i] <= 0;
        m_phase <= (mem_read || mem_write) ? 2 : 0;
      end
    end else if (pmem_resp) begin
      m_line[i] <= pmem_rdata; m_tag[i] <= mem_address[15:6];
      m_valid[i] <= 1; m_dirty[i] <= 0; m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    int i;
    bit req, hit;
    logic [15:0] e_addr;
    i   = int'(mem_address[5:4]);
    req = mem_read || mem_write;
    hit = m_valid[i] && m_tag[i] == mem_address[15:6];
    if (reset) begin
      chk("rst_outputs", {mem_resp, pmem_read, pmem_write, pmem_address, mem_rdata},
          '0);
      chk("rst_wdata", pmem_wdata, '0);
    end else begin
      e_addr = (m_phase == 1) ? {m_tag[i], mem_address[5:4], 4'h0} :
               (m_phase == 2) ? {mem_address[15:6], mem_address[5:4], 4'h0} : 16'h0;
      chk("mem_resp",  mem_resp, (m_phase == 0) && req && hit);
      chk("mem_rdata", mem_rdata, m_line[i][mem_address[3:1]*16 +: 16]);
      chk("pmem_wdata", pmem_wdata, m_line[i]);
      chk("pmem_rw", {pmem_read, pmem_write}, {m_phase == 2, m_phase == 1});
      chk("pmem_address", pmem_address, e_addr);
    end
    if (pmem_read && pmem_write) chk("rw_overlap", 1'b1, 1'b0);
  end

  // Presents one request and services pmem with the given latency until mem_resp.
  task automatic access(input logic [15:0] a, input bit rd, input bit wr,
                        input logic [1:0] be, input logic [15:0] wd, input int lat,
                        output logic [15:0] rdat, output int cyc, output bit sawr,
                        output bit saww, output logic [15:0] raddr,
                        output logic [15:0] waddr, output int gap);
    int pcnt, since;
    bit done;
    mem_address = a; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    cyc = 0; sawr = 0; saww = 0; raddr = 16'h0; waddr = 16'h0; gap = -1;
    pcnt = 0; since = -1; done = 0; rdat = 16'h0;
    while (!done && cyc < 200) begin
      pmem_resp = 1'b0;
      if (pmem_read && !sawr) begin sawr = 1; raddr = pmem_address; end
      if (pmem_write && !saww) begin saww = 1; waddr = pmem_address; end
      if (pmem_read || pmem_write) begin
        pcnt++;
        if (pcnt >= lat) begin
          pmem_resp = 1'b1; pcnt = 0;
          pmem_rdata = pmem_read ? pmem_get(pmem_address) : 128'h0;
        end
      end
      @(negedge clk);
      if (pmem_resp && pmem_write) backing[int'(pmem_address)] = pmem_wdata;
      if (pmem_resp && pmem_read) since = cyc;
      if (mem_resp) begin
        done = 1; rdat = mem_rdata;
        if (since >= 0) gap = cyc - since;
      end
      @(posedge clk); #1;
      cyc++;
    end
    pmem_resp = 1'b0; mem_read = 0; mem_write = 0;
    if (!done) chk("access_timeout", 1'b0, 1'b1);
    cyc--;
  endtask

  logic [15:0] rd, ra, wa;
  int cy, gp;
  bit sr, sw;

  initial begin
    reset = 1; mem_address = 0; mem_read = 0; mem_write = 0;
    mem_byte_enable = 0; mem_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    backing[int'(16'h1230)] = 128'h7777_6666_5555_4444_3333_BEEF_1111_0000;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("after_reset", {mem_resp, pmem_read, pmem_write, pmem_address}, '0);
    @(posedge clk); #1;

    // clean miss then hit
    access(16'h1234, 1, 0, 2'b00, 16'h0, 3, rd, cy, sr, sw, ra, wa, gp);
    chk("fill_addr", ra, 16'h1230);
    chk("fill_rdata", rd, 16'hBEEF);
    chk("fill_gap", gp, 1);
    chk("fill_no_wb", sw, 1'b0);
    access(16'h1234, 1, 0, 2'b00, 16'h0, 3, rd, cy, sr, sw, ra, wa, gp);
    chk("hit_latency", cy, 0);
    chk("hit_no_pmem", {sr, sw}, 2'b00);
    chk("hit_rdata", rd, 16'hBEEF);

    // byte-masked write hit, readable next cycle
    access(16'h1234, 0, 1, 2'b01, 16'hA55A, 3, rd, cy, sr, sw, ra, wa, gp);
    chk("whit_latency", cy, 0);
    access(16'h1234, 1, 0, 2'b00, 16'h0, 3, rd, cy, sr, sw, ra, wa, gp);
    chk("whit_rdata", rd, 16'hBE5A);

    // dirty conflict miss: writeback then fill
    access(16'h5234, 1, 0, 2'b00, 16'h0, 2, rd, cy, sr, sw, ra, wa, gp);
    chk("wb_addr", wa, 16'h1230);
    chk("wb_word2", backing[int'(16'h1230)][47:32], 16'hBE5A);
    chk("wb_word1", backing[int'(16'h1230)][31:16], 16'h1111);
    chk("wb_fill_addr", ra, 16'h5230);
    chk("wb_rdata", rd, 16'h5232);
    chk("wb_gap", gp, 1);

    // clean conflict at index 0: no writeback
    access(16'h0000, 1, 0, 2'b00, 16'h0, 1, rd, cy, sr, sw, ra, wa, gp);
    access(16'h4000, 1, 0, 2'b00, 16'h0, 1, rd, cy, sr, sw, ra, wa, gp);
    chk("clean_no_wb", sw, 1'b0);
    chk("clean_fill", {sr, ra}, {1'b1, 16'h4000});
    chk("clean_rdata", rd, 16'h4000);

    // zero byte-enable write still dirties the line
    access(16'h4002, 0, 1, 2'b00, 16'hFFFF, 1, rd, cy, sr, sw, ra, wa, gp);
    chk("be0_latency", cy, 0);
    access(16'h8000, 1, 0, 2'b00, 16'h0, 1, rd, cy, sr, sw, ra, wa, gp);
    chk("be0_dirty_wb", {sw, wa}, {1'b1, 16'h4000});
    chk("be0_unmodified", backing[int'(16'h4000)][31:16], 16'h4001);

    // read+write together acts as a write
    access(16'h8004, 1, 1, 2'b11, 16'h1357, 1, rd, cy, sr, sw, ra, wa, gp);
    access(16'h8004, 1, 0, 2'b00, 16'h0, 1, rd, cy, sr, sw, ra, wa, gp);
    chk("rw_as_write", rd, 16'h1357);

    // reset during fill abandons it
    mem_address = 16'h2010; mem_read = 1;
    for (int k = 0; k < 20 && !pmem_read; k++) begin @(posedge clk); #1; end
    chk("fill_started", pmem_read, 1'b1);
    @(posedge clk); #1;
    reset = 1; mem_read = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_fill_dropped", {pmem_read, pmem_write, pmem_address}, '0);
    @(posedge clk); #1;
    pmem_resp = 1; pmem_rdata = {8{16'hDEAD}};
    @(posedge clk); #1;
    pmem_resp = 0;
    access(16'h2010, 1, 0, 2'b00, 16'h0, 2, rd, cy, sr, sw, ra, wa, gp);
    chk("refill_miss", {sr, ra}, {1'b1, 16'h2010});
    chk("refill_rdata", rd, 16'h2010);
    access(16'h1234, 1, 0, 2'b00, 16'h0, 2, rd, cy, sr, sw, ra, wa, gp);
    chk("post_rst_miss", {sr, sw}, 2'b10);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
